// File: rtl/result_collector_02.sv
// result_collector_02: tags upstream check calls with a sequence number and queues the results in a DEPTH-entry FIFO.
// Optional saturating sum of popped values is enabled by RESULT_COLLECTOR_02_SUM_EN.
module result_collector_02 #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [5:0] check_d,
    output logic       CHenable,
    input  logic       RDY_check,
    input  logic [5:0] check,
    input  logic       EN_get,
    output logic [5:0] get,
    output logic       RDY_get
`ifdef RESULT_COLLECTOR_02_SUM_EN
    ,
    output logic [9:0] sum,
    output logic       RDY_sum
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_n;
    logic [5:0]    seq;
    logic [0:0]    state;
    logic          full, push, pop;

    always_comb begin
        full     = count == CW'(DEPTH);
        CHenable = RDY_check && !full && state == FILL && !RST;
        RDY_get  = count != '0 && !RST;
        push     = CHenable;
        pop      = EN_get && RDY_get;
        count_n  = count + CW'(push) - CW'(pop);
        check_d  = RST ? 6'd0 : seq;
        get      = mem[rptr];
    end

    always_ff @(posedge CLK)
        if (push)
            mem[wptr] <= check;

    // HOLD tracks a full FIFO; any pop drops count below DEPTH so FILL is restored on that edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            seq   <= '0;
            state <= FILL;
        end else begin
            wptr  <= push ? wptr + 1'b1 : wptr;
            rptr  <= pop ? rptr + 1'b1 : rptr;
            seq   <= push ? seq + 6'd1 : seq;
            count <= count_n;
            state <= count_n == CW'(DEPTH) ? HOLD : FILL;
        end
    end

`ifdef RESULT_COLLECTOR_02_SUM_EN
    logic [10:0] sum_n;
    always_comb begin
        sum_n   = {1'b0, sum} + {5'd0, get};
        RDY_sum = !RST;
    end
    always_ff @(posedge CLK) begin
        if (RST)
            sum <= '0;
        else if (pop)
            sum <= sum_n[10] ? 10'd1023 : sum_n[9:0];
    end
`endif
endmodule

// File: tb/tb_result_collector_02.sv
// tb_result_collector_02: directed checks of fill, full blocking, streaming wrap, empty pops and reset.
// Define RESULT_COLLECTOR_02_SUM_EN to also check the saturating sum.
module tb_result_collector_02;
    logic       CLK = 0;
    logic       RST = 1;
    logic [5:0] check_d;
    logic       CHenable;
    logic       RDY_check = 0;
    logic [5:0] check = 0;
    logic       EN_get = 0;
    logic [5:0] get;
    logic       RDY_get;
`ifdef RESULT_COLLECTOR_02_SUM_EN
    logic [9:0] sum;
    logic       RDY_sum;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    result_collector_02 #(.DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .check_d(check_d), .CHenable(CHenable),
        .RDY_check(RDY_check), .check(check), .EN_get(EN_get),
        .get(get), .RDY_get(RDY_get)
`ifdef RESULT_COLLECTOR_02_SUM_EN
        , .sum(sum), .RDY_sum(RDY_sum)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [5:0] q[$];
        logic [5:0] v;
        logic [5:0] exp_get[4];
        int seq_m;
        int sum_m;
        logic wrapped;
        logic [5:0] prev_d;
        exp_get = '{6'd5, 6'd5, 6'd5, 6'd9};
        RDY_check = 1;
        check = 5;
        tick;
        tick;
        chk("rst_chenable", CHenable, 0);
        chk("rst_rdy_get", RDY_get, 0);
        chk("rst_check_d", check_d, 0);
`ifdef RESULT_COLLECTOR_02_SUM_EN
        chk("rst_rdy_sum", RDY_sum, 0);
`endif
        RST = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_chenable", CHenable, 1);
            chk("fill_check_d", check_d, i);
            tick;
        end
        chk("full_chenable", CHenable, 0);
        chk("full_check_d", check_d, 4);
        chk("full_rdy_get", RDY_get, 1);
        chk("full_get", get, 5);
        tick;
        chk("full_no_push", check_d, 4);

        EN_get = 1;
        check = 9;
        #1;
        chk("popfull_chenable", CHenable, 0);
        chk("popfull_rdy_get", RDY_get, 1);
        tick;
        EN_get = 0;
        #1;
        chk("resume_chenable", CHenable, 1);
        chk("resume_check_d", check_d, 4);
        tick;
        chk("refill_check_d", check_d, 5);
        chk("refill_chenable", CHenable, 0);

        RDY_check = 0;
        EN_get = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_rdy_get", RDY_get, 1);
            chk("drain_get", get, exp_get[i]);
            tick;
        end
        chk("drained_rdy_get", RDY_get, 0);
`ifdef RESULT_COLLECTOR_02_SUM_EN
        chk("drained_sum", sum, 29);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("empty_pop_rdy_get", RDY_get, 0);
            tick;
        end
        chk("empty_pop_check_d", check_d, 5);
`ifdef RESULT_COLLECTOR_02_SUM_EN
        chk("empty_pop_sum", sum, 29);
`endif

        seq_m = 5;
        sum_m = 29;
        wrapped = 0;
        prev_d = 5;
        for (int i = 0; i < 70; i++) begin
            v = 6'((i * 7 + 3) % 64);
            check = v;
            RDY_check = 1;
            EN_get = 1;
            #1;
            chk("stream_chenable", CHenable, 1);
            chk("stream_check_d", check_d, seq_m);
            chk("stream_rdy_get", RDY_get, q.size() > 0);
            if (prev_d == 63 && check_d == 0)
                wrapped = 1;
            prev_d = check_d;
            if (q.size() > 0) begin
                chk("stream_get", get, q[0]);
                sum_m = sum_m + q[0] > 1023 ? 1023 : sum_m + q[0];
                void'(q.pop_front());
            end
            q.push_back(v);
            seq_m = (seq_m + 1) % 64;
            tick;
        end
        RDY_check = 0;
        #1;
        chk("stream_last_get", get, q[0]);
        sum_m = sum_m + q[0] > 1023 ? 1023 : sum_m + q[0];
        void'(q.pop_front());
        tick;
        chk("stream_end_rdy_get", RDY_get, 0);
        chk("stream_end_check_d", check_d, 11);
        chk("stream_wrapped", wrapped, 1);
`ifdef RESULT_COLLECTOR_02_SUM_EN
        chk("stream_sum", sum, sum_m);
`endif

        EN_get = 0;
        RDY_check = 1;
        check = 17;
        tick;
        tick;
        tick;
        RDY_check = 0;
        #1;
        chk("three_rdy_get", RDY_get, 1);
        chk("three_get", get, 17);
        RST = 1;
        RDY_check = 1;
        #1;
        chk("midrst_chenable", CHenable, 0);
        chk("midrst_rdy_get", RDY_get, 0);
        chk("midrst_check_d", check_d, 0);
        tick;
        RST = 0;
        RDY_check = 0;
        #1;
        chk("postrst_rdy_get", RDY_get, 0);
        chk("postrst_check_d", check_d, 0);
`ifdef RESULT_COLLECTOR_02_SUM_EN
        chk("postrst_sum", sum, 0);
        chk("postrst_rdy_sum", RDY_sum, 1);
        check = 63;
        EN_get = 1;
        for (int i = 0; i < 25; i++) begin
            RDY_check = i < 20;
            tick;
        end
        chk("sat_sum", sum, 1023);
        chk("sat_rdy_get", RDY_get, 0);
        chk("sat_check_d", check_d, 20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/result_collector_02.md
RESULT_COLLECTOR_02 -- requirements
Module: result_collector_02

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port check_d, output, 6 bits: argument to the upstream check method; it carries the current sequence tag.
REQ-005 The block SHALL have the port CHenable, output, 1 bit: enable of the upstream check action-value method.
REQ-006 The block SHALL have the port RDY_check, input, 1 bit: upstream check method ready.
REQ-007 The block SHALL have the port check, input, 6 bits: value returned by upstream check, valid when CHenable is high.
REQ-008 The block SHALL have the port EN_get, input, 1 bit: downstream dequeue enable.
REQ-009 The block SHALL have the port get, output, 6 bits: FIFO head value.
REQ-010 The block SHALL have the port RDY_get, output, 1 bit: FIFO not empty.
REQ-011 The block SHALL have the port sum, output, 10 bits: saturating accumulator; present only with the macro in REQ-027.
REQ-012 The block SHALL have the port RDY_sum, output, 1 bit: sum valid; present only with the macro in REQ-027.

Function
REQ-013 The block SHALL drive CHenable = RDY_check AND NOT full AND NOT RST, combinationally.
REQ-014 The block SHALL write check into the tail entry on every rising edge with CHenable high; capture latency is 1 cycle, so the value is visible on get no earlier than the next cycle.
REQ-015 The block SHALL drive check_d from a 6-bit sequence register that increments by 1 on each transfer and wraps from 63 to 0.
REQ-016 The block SHALL drive RDY_get = (count != 0) AND NOT RST, and SHALL drive get combinationally from the head entry.
REQ-017 The block SHALL pop the head on an edge where EN_get AND RDY_get are both high; EN_get while RDY_get is low SHALL be ignored with no state change.
REQ-018 When full, the block SHALL block a push even if a pop occurs in the same cycle (no full-bypass); that cycle's pop SHALL proceed normally.
REQ-019 When a push and a pop occur together at 0 < count < DEPTH, the block SHALL leave count unchanged and advance both pointers.
REQ-020 The block SHALL wrap its read/write pointers modulo DEPTH, keep a count of width log2(DEPTH)+1, and assert full when count = DEPTH.
REQ-021 The block SHALL use a two-state state machine: FILL (CHenable is permitted) and HOLD (entered when count reaches DEPTH; CHenable is forced low). It SHALL return to FILL on the first edge after a pop.
REQ-022 The block SHALL never lose, duplicate or reorder data: get order equals check capture order.

Reset
REQ-023 While RST is high at a rising edge, the block SHALL clear pointers, count, sequence and sum to 0 and set the state to FILL.
REQ-024 During reset, the block SHALL hold CHenable = 0, RDY_get = 0 and check_d = 0, and RDY_sum = 0 when present.
REQ-025 Reset mid-operation SHALL discard all stored entries; entry contents need not be cleared, but SHALL never be presented with RDY_get high.
REQ-026 The first CHenable SHALL be possible in the first cycle with RST low.

Configuration
REQ-027 The macro RESULT_COLLECTOR_02_SUM_EN SHALL control the accumulator. When defined, sum SHALL add each popped get value (zero-extended) on the pop edge, saturate at 1023, and RDY_sum SHALL equal NOT RST. When undefined, the sum and RDY_sum ports and their accumulator logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 The bench SHALL cover: reset release with RDY_check=1 and check=5 held, no EN_get -> exactly 4 pushes, check_d steps 0,1,2,3,4; then CHenable=0 and RDY_get=1 with get=5.
REQ-029 The bench SHALL cover: a full FIFO with EN_get=1 and RDY_check=1 in the same cycle -> pop occurs, no push that cycle, push resumes the next cycle.
REQ-030 The bench SHALL cover: 70 transfers with continuous EN_get -> check_d wraps 63->0, and the get sequence matches the captured values in order.
REQ-031 The bench SHALL cover: EN_get=1 while the FIFO is empty -> pointers, count and sum unchanged, and RDY_get stays 0.
REQ-032 The bench SHALL cover: RST pulsed for 1 cycle with 3 entries held -> next cycle RDY_get=0, check_d=0, sum=0.
REQ-033 The bench SHALL cover, with RESULT_COLLECTOR_02_SUM_EN defined: 20 pops of value 63 -> sum=1023, saturated (not 1260).
